// File: rtl/maindec_pipe.sv
// -----------------------------------------------------------------------------
// maindec_pipe
//
// Registered, handshaked MIPS32 main decoder. Decodes the integer subset into
// a control word, holds that word in a one-entry valid/ready output register,
// and interlocks HI/LO-dependent instructions against a multi-cycle mult/div
// unit by means of an internal busy counter.
//
// Parameters
//   MUL_CYCLES : cycles the HI/LO unit is busy after MULT/MULTU issues (1..255)
//   DIV_CYCLES : cycles the HI/LO unit is busy after DIV/DIVU issues   (1..255)
//   CNT_W      : busy counter width, must hold max(MUL_CYCLES, DIV_CYCLES)
//
// Ports
//   clk, rst               : clock (rising edge), async active-high reset
//   in_valid / in_ready    : instruction handshake from IF/ID
//   instr[31:0]            : instruction word
//   flush                  : kill the held control word
//   out_valid / out_ready  : control word handshake to ID-stage consumers
//   regwrite..jal, regdst  : registered datapath control
//   hilo_write, md_start   : HI/LO write, mult/div issue
//   syscall, brk, ri       : trap / reserved-instruction decode
//   md_busy                : busy counter non-zero
//
// Configuration
//   MAINDEC_RI_EN : when defined, undefined encodings raise ri; otherwise ri
//                   is constant 0 and undefined encodings decode as all-zero.
// -----------------------------------------------------------------------------
module maindec_pipe #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        regwrite,
    output logic        alusrc,
    output logic        branch,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        jump,
    output logic        jr,
    output logic        jal,
    output logic [1:0]  regdst,
    output logic        hilo_write,
    output logic        md_start,
    output logic        syscall,
    output logic        brk,
    output logic        ri,
    output logic        md_busy
);

`ifdef MAINDEC_RI_EN
    localparam logic RI_EN = 1'b1;
`else
    localparam logic RI_EN = 1'b0;
`endif

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic       jr;
        logic       jal;
        logic [1:0] regdst;
        logic       hilo_write;
        logic       md_start;
        logic       md_div;     // internal: selects DIV_CYCLES on issue
        logic       syscall;
        logic       brk;
        logic       ri;
    } ctrl_t;

    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign rt    = instr[20:16];
    assign funct = instr[5:0];

    // rs, rd, shamt and the upper immediate bits play no part in decode.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[25:21], instr[15:6]};

    ctrl_t          ctrl_d, ctrl_q;
    logic           is_hilo_op;
    logic           out_valid_d, out_valid_q;
    logic [CNT_W-1:0] busy_d, busy_q;
    logic           hazard, load, consume;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first so that no
        // path through the case statements leaves it unassigned (no latches).
        ctrl_d     = '0;
        is_hilo_op = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b000000, 6'b000010, 6'b000011,          // SLL SRL SRA
                    6'b000100, 6'b000110, 6'b000111,          // SLLV SRLV SRAV
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011: begin
                        ctrl_d.regwrite = 1'b1;
                        ctrl_d.regdst   = RD_RD;
                    end
                    6'b010000, 6'b010010: begin               // MFHI MFLO
                        ctrl_d.regwrite = 1'b1;
                        ctrl_d.regdst   = RD_RD;
                        is_hilo_op      = 1'b1;
                    end
                    6'b010001, 6'b010011: begin               // MTHI MTLO
                        ctrl_d.hilo_write = 1'b1;
                        is_hilo_op        = 1'b1;
                    end
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        ctrl_d.hilo_write = 1'b1;
                        ctrl_d.md_start   = 1'b1;
                        ctrl_d.md_div     = funct[1];         // DIV/DIVU
                        is_hilo_op        = 1'b1;
                    end
                    6'b001000: ctrl_d.jr = 1'b1;              // JR
                    6'b001001: begin                          // JALR
                        ctrl_d.regwrite = 1'b1;
                        ctrl_d.regdst   = RD_RD;
                        ctrl_d.jr       = 1'b1;
                        ctrl_d.jal      = 1'b1;
                    end
                    6'b001100: ctrl_d.syscall = 1'b1;
                    6'b001101: ctrl_d.brk     = 1'b1;
                    default:   ctrl_d.ri      = RI_EN;
                endcase
            end
            6'b000001: begin                                  // REGIMM
                case (rt)
                    5'b00000, 5'b00001: ctrl_d.branch = 1'b1; // BLTZ BGEZ
                    5'b10000, 5'b10001: begin                 // BLTZAL BGEZAL
                        ctrl_d.branch   = 1'b1;
                        ctrl_d.regwrite = 1'b1;
                        ctrl_d.regdst   = RD_R31;
                        ctrl_d.jal      = 1'b1;
                    end
                    default: ctrl_d.ri = RI_EN;
                endcase
            end
            6'b000010: ctrl_d.jump = 1'b1;                    // J
            6'b000011: begin                                  // JAL
                ctrl_d.jump     = 1'b1;
                ctrl_d.jal      = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.regdst   = RD_R31;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111:       // BEQ BNE BLEZ BGTZ
                ctrl_d.branch = 1'b1;
            6'b001000, 6'b001001, 6'b001010, 6'b001011,       // ADDI..LUI
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
            end
            6'b100000, 6'b100001, 6'b100011,                  // LB LH LW
            6'b100100, 6'b100101: begin                       // LBU LHU
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memtoreg = 1'b1;
            end
            6'b101000, 6'b101001, 6'b101011: begin            // SB SH SW
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
            end
            default: ctrl_d.ri = RI_EN;
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake and interlock
    // -------------------------------------------------------------------------
    // A held HI/LO writer counts as in flight until it leaves the register,
    // because the counter only starts on the cycle after it is consumed.
    assign hazard   = is_hilo_op & ((busy_q != '0) | (out_valid_q & ctrl_q.hilo_write));
    assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
    assign load     = in_valid & in_ready;
    // flush kills the held word, so it cannot be consumed in the same cycle.
    assign consume  = out_valid_q & out_ready & ~flush;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (load)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
    end

    always_comb begin
        busy_d = busy_q;
        if (consume && ctrl_q.md_start)
            busy_d = ctrl_q.md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        else if (busy_q != '0)
            busy_d = busy_q - 1'b1;
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            if (load)
                ctrl_q <= ctrl_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign regwrite   = ctrl_q.regwrite;
    assign alusrc     = ctrl_q.alusrc;
    assign branch     = ctrl_q.branch;
    assign memwrite   = ctrl_q.memwrite;
    assign memtoreg   = ctrl_q.memtoreg;
    assign jump       = ctrl_q.jump;
    assign jr         = ctrl_q.jr;
    assign jal        = ctrl_q.jal;
    assign regdst     = ctrl_q.regdst;
    assign hilo_write = ctrl_q.hilo_write;
    assign md_start   = ctrl_q.md_start;
    assign syscall    = ctrl_q.syscall;
    assign brk        = ctrl_q.brk;
    assign ri         = ctrl_q.ri;
    assign md_busy    = (busy_q != '0);

endmodule
